// File: rtl/mem_bus_if.sv
// Single-ported memory bus between the fetch/data arbiter and memory.
// master: req/we/sel/addr/wdata/err out, rdata/ack in; slave: mirror.
interface mem_bus_if;
  logic        req;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        err;

  modport master (
    output req, we, sel, addr, wdata, err,
    input  rdata, ack
  );

  modport slave (
    input  req, we, sel, addr, wdata, err,
    output rdata, ack
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between IF fetches and MEM data accesses.
// Ports: clk, rst, if_* (fetch), mem_* (data), bus (mem_bus_if.master).
module mem_port_arbiter #(
  parameter int MAX_DBURST  = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_stall,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_stall,
  mem_bus_if.master   bus
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IF,
    BUSY_D
  } state_t;

  localparam logic [3:0] BMAX  = 4'(MAX_DBURST);
  localparam logic [7:0] WLAST = 8'(TIMEOUT_CYC - 1);

  state_t      state;
  state_t      state_nx;
  logic [3:0]  burst;
  logic [7:0]  wcnt;
  logic        tmo;
  logic        done_if;
  logic        done_d;
  logic        grant_d;
  logic        grant_if;
  logic [31:0] rd_now;

  logic        req_q;
  logic        we_q;
  logic        err_q;
  logic [3:0]  sel_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] if_rd_q;
  logic [31:0] mem_rd_q;

  assign bus.req   = req_q;
  assign bus.we    = we_q;
  assign bus.sel   = sel_q;
  assign bus.addr  = addr_q;
  assign bus.wdata = wdata_q;
  assign bus.err   = err_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          grant_d:  state_nx = BUSY_D;
          grant_if: state_nx = BUSY_IF;
          default:  state_nx = IDLE;
        endcase
      end
      BUSY_IF: if (done_if) state_nx = IDLE;
      BUSY_D:  if (done_d)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    // ack beats a coincident timeout
    tmo      = !bus.ack && (wcnt == WLAST);
    done_if  = (state == BUSY_IF) && (bus.ack || tmo);
    done_d   = (state == BUSY_D)  && (bus.ack || tmo);
    grant_d  = (state == IDLE) && mem_req
             && !(if_req && (burst == BMAX));
    grant_if = (state == IDLE) && !grant_d && if_req;
    rd_now   = bus.ack ? bus.rdata : 32'h0;
    if_rdata  = done_if ? rd_now : if_rd_q;
    mem_rdata = done_d  ? rd_now : mem_rd_q;
    if_stall  = if_req  && !done_if;
    mem_stall = mem_req && !done_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      sel_q    <= 4'h0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      if_rd_q  <= 32'h0;
      mem_rd_q <= 32'h0;
      burst    <= 4'h0;
      wcnt     <= 8'h0;
    end else begin
      err_q <= 1'b0;
      if (grant_d) begin
        req_q   <= 1'b1;
        we_q    <= mem_we;
        sel_q   <= mem_sel;
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
      end else if (grant_if) begin
        req_q   <= 1'b1;
        we_q    <= 1'b0;
        sel_q   <= 4'hF;
        addr_q  <= if_addr;
        wdata_q <= 32'h0;
      end
      if (done_if || done_d) begin
        req_q <= 1'b0;
        err_q <= tmo;
      end
      if (done_if) if_rd_q  <= rd_now;
      if (done_d)  mem_rd_q <= rd_now;
      // IDLE holds it at zero so every BUSY entry starts from 0
      if (state == IDLE || done_if || done_d)
        wcnt <= 8'h0;
      else
        wcnt <= wcnt + 8'h1;
      if (!if_req || done_if)
        burst <= 4'h0;
      else if (done_d && burst != BMAX)
        burst <= burst + 4'h1;
    end
  end

endmodule
